rng_lfsr_core: RTL and testbench
================================

// Module: rng_lfsr_core
// PURPOSE
//   Random-number core fed directly by the tt_um_rng pin wrapper: mode[1:0] <- ui_in[5:4],
//   seed[3:0] <- ui_in[3:0], output_data[7:0] -> uo_out.
//   Holds a 16-bit Galois LFSR that can be seeded from the pins.
//   Presents either raw bytes, divided-rate bytes or dice rolls (1..6) on output_data.
// PARAMETERS
//   LFSR_W    16        LFSR width; taps fixed for 16 (mask TAPS below).
//   TAPS      16'hB400  Galois right-shift feedback mask (x^16+x^14+x^13+x^11+1).
//   SEED_DEF  16'hACE1  LFSR value after reset and zero-lock recovery.
//   DIV_W     4         SLOW mode steps once every 2**DIV_W cycles.
// PORTS
//   clk          in   1  single clock; all state changes on rising edge.
//   reset        in   1  synchronous, active-high reset.
//   mode         in   2  00 LOAD, 01 RAW, 10 SLOW, 11 DICE.
//   seed         in   4  seed nibble, sampled in LOAD mode only.
//   output_data  out  8  registered result byte.
// BEHAVIOUR
//   Reset (sync, active-high): lfsr=SEED_DEF, output_data=8'h00, div_cnt=0, prev_mode=00.
//     reset has priority over every mode, including mid-count in SLOW.
//   step(x) = (x>>1) ^ (x[0] ? TAPS : 0); next = step(lfsr).
//   Zero guard: if lfsr==0, the next edge loads SEED_DEF regardless of mode (output holds).
//   LOAD (00): every cycle lfsr <= {seed,~seed,seed,~seed} (never zero); output_data holds.
//   RAW  (01): every cycle lfsr <= next; output_data <= next[7:0]; latency 1 clk.
//   SLOW (10): div_cnt increments every cycle.
//     At div_cnt == 2**DIV_W-1: lfsr <= next, output_data <= next[7:0], div_cnt wraps to 0.
//     Otherwise lfsr and output_data hold.
//   DICE (11): every cycle lfsr <= next; c = next[2:0].
//     If 1<=c<=6: output_data <= {5'b0,c}.
//     If c==0 or c==7: rejected, output_data holds previous value.
//   Mode change: prev_mode registers mode each cycle.
//     When mode != prev_mode, div_cnt is forced to 0 this edge.
//     First SLOW step therefore lands exactly 2**DIV_W edges after entering SLOW.
//     The new mode's action takes effect on the first edge at which it is sampled.
//   Wrap-around: div_cnt is DIV_W bits and wraps naturally.
//     The LFSR period is 65535; the all-zero state is unreachable except by fault (guarded).
//   No handshake: output_data is a level; consumers sample at will.
// TESTING
//   1 reset, mode=01 -> output_data 8'h70, 8'h38, 8'h9C on edges 1..3
//     (lfsr E270, 7138, 389C).
//   2 mode=00 seed=4'h3 for 2 clks, then mode=01 -> lfsr 3C3C loaded;
//     first RAW edge output_data=8'h1E; output held during LOAD.
//   3 reset, mode=10 (DIV_W=4) -> output_data stays 8'h00 for 15 edges;
//     8'h70 on the 16th edge; 8'h38 on the 32nd edge.
//   4 reset, mode=11 -> edges 1,2 rejected (c=0), output_data stays 8'h00;
//     edge 3 output_data=8'h04.
//   5 mode=01 for 5 clks, assert reset 1 clk, deassert -> output_data=8'h00 after reset edge;
//     sequence restarts at 8'h70.
//   6 force lfsr=0 via hierarchical deposit in mode=01 -> next edge lfsr=ACE1, output held;
//     following edge output_data=8'h70.

Source files
------------

// File: rtl/rng_lfsr_core.sv
// Random-number core: 16-bit Galois LFSR, pin-seedable, presenting raw bytes,
// divided-rate bytes or rejection-sampled dice rolls (1..6) on a registered byte.
module rng_lfsr_core #(
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED_DEF = 16'hACE1,
    parameter int                DIV_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic [3:0] seed,
    output logic [7:0] output_data
);

    localparam logic [1:0]       MODE_LOAD = 2'b00;
    localparam logic [1:0]       MODE_RAW  = 2'b01;
    localparam logic [1:0]       MODE_SLOW = 2'b10;
    localparam logic [1:0]       MODE_DICE = 2'b11;
    localparam logic [DIV_W-1:0] DIV_MAX   = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
        return (x >> 1) ^ (x[0] ? TAPS : {LFSR_W{1'b0}});
    endfunction

    logic [LFSR_W-1:0] lfsr_r;
    logic [7:0]        data_r;
    logic [DIV_W-1:0]  div_cnt_r;
    logic [1:0]        prev_mode_r;

    logic [LFSR_W-1:0] next_s;
    logic [LFSR_W-1:0] load_val_s;
    logic [LFSR_W-1:0] lfsr_d_s;
    logic [7:0]        data_d_s;
    logic [DIV_W-1:0]  div_eff_s;
    logic [DIV_W-1:0]  div_d_s;
    logic [2:0]        dice_c_s;
    logic              dice_ok_s;

    // Next-state and output selection for the current mode.
    always_comb begin
        next_s     = lfsr_step(lfsr_r);
        load_val_s = {seed, ~seed, seed, ~seed};
        // A mode change restarts the divider so the first SLOW step lands a full period later.
        div_eff_s  = (mode != prev_mode_r) ? {DIV_W{1'b0}} : div_cnt_r;
        dice_c_s   = next_s[2:0];
        dice_ok_s  = (dice_c_s != 3'd0) && (dice_c_s != 3'd7);
        lfsr_d_s   = lfsr_r;
        data_d_s   = data_r;
        div_d_s    = div_eff_s;
        if (lfsr_r == {LFSR_W{1'b0}}) begin
            lfsr_d_s = SEED_DEF;
        end else begin
            case (mode)
                MODE_LOAD: begin
                    lfsr_d_s = load_val_s;
                end
                MODE_RAW: begin
                    lfsr_d_s = next_s;
                    data_d_s = next_s[7:0];
                end
                MODE_SLOW: begin
                    div_d_s = div_eff_s + DIV_ONE;
                    if (div_eff_s == DIV_MAX) begin
                        lfsr_d_s = next_s;
                        data_d_s = next_s[7:0];
                    end else begin
                        lfsr_d_s = lfsr_r;
                        data_d_s = data_r;
                    end
                end
                MODE_DICE: begin
                    lfsr_d_s = next_s;
                    if (dice_ok_s) begin
                        data_d_s = {5'b00000, dice_c_s};
                    end else begin
                        data_d_s = data_r;
                    end
                end
                default: begin
                    lfsr_d_s = lfsr_r;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over every mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r      <= SEED_DEF;
            data_r      <= 8'h00;
            div_cnt_r   <= {DIV_W{1'b0}};
            prev_mode_r <= MODE_LOAD;
        end else begin
            lfsr_r      <= lfsr_d_s;
            data_r      <= data_d_s;
            div_cnt_r   <= div_d_s;
            prev_mode_r <= mode;
        end
    end

    assign output_data = data_r;

endmodule

// File: tb/tb_rng_lfsr_core.sv
// Directed and randomized checks of rng_lfsr_core against a behavioural model.
module tb_rng_lfsr_core;

    logic       clk;
    logic       reset;
    logic [1:0] mode;
    logic [3:0] seed;
    logic [7:0] output_data;

    int n_cmp;
    int n_bad;

    logic [15:0] m_lfsr;
    logic [7:0]  m_out;
    logic [1:0]  m_prev;
    int          m_slow_n;

    rng_lfsr_core dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .seed        (seed),
        .output_data (output_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_next(input logic [15:0] x);
        int v;
        v = x;
        if (v % 2 == 1) return 16'(v / 2) ^ 16'hB400;
        else            return 16'(v / 2);
    endfunction

    // Behavioural model: SLOW steps on every 16th edge counted from entry into SLOW.
    task automatic model_edge(input logic r, input logic [1:0] m, input logic [3:0] s);
        logic [15:0] nx;
        int c;
        if (r) begin
            m_lfsr   = 16'hACE1;
            m_out    = 8'h00;
            m_prev   = 2'd0;
            m_slow_n = 0;
        end else begin
            if (m == 2'd2) m_slow_n = (m != m_prev) ? 1 : m_slow_n + 1;
            if (m_lfsr == 16'h0000) begin
                m_lfsr = 16'hACE1;
            end else begin
                nx = ref_next(m_lfsr);
                case (m)
                    2'd0: m_lfsr = {s, ~s, s, ~s};
                    2'd1: begin m_lfsr = nx; m_out = 8'(nx % 256); end
                    2'd2: if (m_slow_n % 16 == 0) begin m_lfsr = nx; m_out = 8'(nx % 256); end
                    default: begin
                        m_lfsr = nx;
                        c = nx % 8;
                        if (c >= 1 && c <= 6) m_out = 8'(c);
                    end
                endcase
            end
            m_prev = m;
        end
    endtask

    task automatic step_clk(input logic r, input logic [1:0] m, input logic [3:0] s);
        reset = r;
        mode  = m;
        seed  = s;
        @(posedge clk);
        model_edge(r, m, s);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        mode  = 2'd0;
        seed  = 4'h0;
        m_lfsr = 16'hACE1; m_out = 8'h00; m_prev = 2'd0; m_slow_n = 0;

        // Reset then RAW sequence
        step_clk(1'b1, 2'd1, 4'h0);
        check("reset_out", output_data, 8'h00);
        step_clk(1'b0, 2'd1, 4'h0); check("raw_e1", output_data, 8'h70);
        step_clk(1'b0, 2'd1, 4'h0); check("raw_e2", output_data, 8'h38);
        step_clk(1'b0, 2'd1, 4'h0); check("raw_e3", output_data, 8'h9C);

        // LOAD seed 3 holds output, then first RAW edge
        step_clk(1'b0, 2'd0, 4'h3); check("load_hold1", output_data, 8'h9C);
        step_clk(1'b0, 2'd0, 4'h3); check("load_hold2", output_data, 8'h9C);
        step_clk(1'b0, 2'd1, 4'h0); check("load_raw", output_data, 8'h1E);

        // SLOW: 15 quiet edges, step on 16th and 32nd
        step_clk(1'b1, 2'd2, 4'h0); check("slow_reset", output_data, 8'h00);
        for (int i = 1; i <= 15; i++) begin
            step_clk(1'b0, 2'd2, 4'h0); check("slow_quiet", output_data, 8'h00);
        end
        step_clk(1'b0, 2'd2, 4'h0); check("slow_e16", output_data, 8'h70);
        for (int i = 17; i <= 31; i++) begin
            step_clk(1'b0, 2'd2, 4'h0); check("slow_hold", output_data, 8'h70);
        end
        step_clk(1'b0, 2'd2, 4'h0); check("slow_e32", output_data, 8'h38);

        // DICE rejection then accept
        step_clk(1'b1, 2'd3, 4'h0);
        step_clk(1'b0, 2'd3, 4'h0); check("dice_rej1", output_data, 8'h00);
        step_clk(1'b0, 2'd3, 4'h0); check("dice_rej2", output_data, 8'h00);
        step_clk(1'b0, 2'd3, 4'h0); check("dice_e3", output_data, 8'h04);

        // Reset mid-RAW restarts the sequence
        for (int i = 0; i < 5; i++) step_clk(1'b0, 2'd1, 4'h0);
        step_clk(1'b1, 2'd1, 4'h0); check("midreset_out", output_data, 8'h00);
        step_clk(1'b0, 2'd1, 4'h0); check("midreset_e1", output_data, 8'h70);
        step_clk(1'b0, 2'd1, 4'h0); check("midreset_e2", output_data, 8'h38);

        // Zero-lock recovery: deposit zero, output holds, then sequence resumes from SEED_DEF
        force dut.lfsr_r = 16'h0000;
        #1;
        release dut.lfsr_r;
        m_lfsr = 16'h0000;
        step_clk(1'b0, 2'd1, 4'h0); check("zero_hold", output_data, 8'h38);
        step_clk(1'b0, 2'd1, 4'h0); check("zero_resume", output_data, 8'h70);

        // Randomized sticky-mode traffic against the model
        step_clk(1'b1, 2'd0, 4'h0);
        mode = 2'($urandom_range(0, 3));
        for (int i = 0; i < 600; i++) begin
            logic [1:0] nm;
            logic       nr;
            nm = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(0, 3)) : mode;
            nr = ($urandom_range(0, 99) == 0);
            step_clk(nr, nm, 4'($urandom_range(0, 15)));
            check("random", output_data, m_out);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
